vicii_sprite_mux: RTL and testbench

Consumer end of the eight per-sprite pixel streams (pixel_enable/pixel) produced by the sprite units. Each pixel slot, it resolves sprite-vs-sprite and sprite-vs-background priority to yield the final foreground colour. It also latches sprite-sprite (MM, $D01E) and sprite-data (MD, $D01F) collisions with clear-on-read semantics, and raises collision interrupt pulses toward the IRQ block. It sits between the sprite units and the graphics and border pixel mux.

---
 rtl/vicii_pkg.sv | 17 +
 rtl/vicii_prio_enc.sv | 30 +++
 rtl/vicii_sprite_mux.sv | 189 ++++++++++++++++++
 tb/tb_vicii_sprite_mux.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vicii_pkg.sv
// rtl/vicii_pkg.sv - shared constants and types for the VIC-II sprite pixel path
//
// Purpose: register addresses of the collision latches, default sprite count
// and the 4-bit colour type used by every pixel-carrying signal.
package vicii_pkg;

  // Collision register offsets within the VIC-II register window.
  localparam logic [5:0] ADDR_MM = 6'h1E;  // sprite-sprite collision ($D01E)
  localparam logic [5:0] ADDR_MD = 6'h1F;  // sprite-data collision ($D01F)

  // The register map (8-bit enable/priority/collision registers) assumes 8.
  localparam int NSPR_DEFAULT = 8;

  // VIC-II palette index.
  typedef logic [3:0] color_t;

endpackage

// File: rtl/vicii_prio_enc.sv
// rtl/vicii_prio_enc.sv - lowest-index-wins priority encoder with an any flag
//
// Purpose: returns the index of the lowest set bit of req (bit 0 has the
// highest priority) and whether any bit is set at all.
// Ports:
//   req  in   N       request vector
//   idx  out  IW      index of the lowest set bit; 0 when req is empty
//   any  out  1       1 = at least one bit of req is set
module vicii_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scanning from the top down lets the lowest set bit overwrite the rest,
  // so the final assignment is the highest-priority request.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vicii_sprite_mux.sv
// rtl/vicii_sprite_mux.sv - sprite priority mux and collision latches
//
// Purpose: per pixel slot, picks the winning sprite among the active ones,
// resolves it against the graphics foreground, and latches sprite-sprite (MM)
// and sprite-data (MD) collisions with clear-on-read and IRQ pulses.
// Ports:
//   clk        in   1        system clock
//   reset      in   1        synchronous, active-high reset
//   pix_en     in   1        pixel-slot qualifier; pixel/collision logic advances only when 1
//   spr_en     in   NSPR     per-sprite pixel enable from the sprite units
//   spr_pix    in   4*NSPR   per-sprite colour, sprite n at [4n+3:4n]
//   ME         in   NSPR     sprite enable register ($D015)
//   MDP        in   NSPR     sprite-data priority ($D01B), 1 = behind graphics
//   bg_pix     in   4        graphics/background colour for this slot
//   bg_fg      in   1        1 = graphics pixel is foreground
//   reg_rd     in   1        CPU register read strobe, one clk wide
//   reg_addr   in   6        CPU register address
//   pixel_out  out  4        resolved colour (1 clk latency)
//   spr_hit    out  1        1 = pixel_out comes from a sprite
//   rd_data    out  8        read data for $1E/$1F, else 0
//   rd_hit     out  1        1 = rd_data is valid for the last reg_rd
//   irq_mmc    out  1        one-clk pulse on a new sprite-sprite collision
//   irq_mbc    out  1        one-clk pulse on a new sprite-data collision
module vicii_sprite_mux
  import vicii_pkg::*;
#(
  parameter int NSPR = NSPR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [NSPR-1:0]   spr_en,
  input  logic [4*NSPR-1:0] spr_pix,
  input  logic [NSPR-1:0]   ME,
  input  logic [NSPR-1:0]   MDP,
  input  logic [3:0]        bg_pix,
  input  logic              bg_fg,
  input  logic              reg_rd,
  input  logic [5:0]        reg_addr,
  output logic [3:0]        pixel_out,
  output logic              spr_hit,
  output logic [7:0]        rd_data,
  output logic              rd_hit,
  output logic              irq_mmc,
  output logic              irq_mbc
);

  localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam logic [NSPR-1:0] ONE = NSPR'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  color_t          pixel_out_q, pixel_out_d;
  logic            spr_hit_q,   spr_hit_d;
  logic [7:0]      rd_data_q,   rd_data_d;
  logic            rd_hit_q,    rd_hit_d;
  logic            irq_mmc_q,   irq_mmc_d;
  logic            irq_mbc_q,   irq_mbc_d;
  logic [NSPR-1:0] mm_q,        mm_d;
  logic [NSPR-1:0] md_q,        md_d;

  // ---------------------------------------------------------------------------
  // Winner select
  // ---------------------------------------------------------------------------
  logic [NSPR-1:0] act;
  logic [IW-1:0]   win;
  logic            win_any;
  color_t          win_pix;
  logic            win_behind;

  assign act = spr_en & ME;

  vicii_prio_enc #(
    .N  (NSPR),
    .IW (IW)
  ) u_prio_enc (
    .req (act),
    .idx (win),
    .any (win_any)
  );

  always_comb begin
    win_pix = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (win == IW'(i)) begin
        win_pix = spr_pix[4*i +: 4];
      end
    end
  end

  // Only the winner's priority bit matters: a lower sprite in front of the
  // graphics never shows through a winner hidden behind them.
  assign win_behind = MDP[win] & bg_fg;

  // ---------------------------------------------------------------------------
  // Collision sets
  // ---------------------------------------------------------------------------
  logic            multi_act;
  logic [NSPR-1:0] new_mm;
  logic [NSPR-1:0] new_mb;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_act = |(act & (act - ONE));
  assign new_mm    = (pix_en && multi_act) ? act : '0;
  assign new_mb    = (pix_en && bg_fg)     ? act : '0;

  // ---------------------------------------------------------------------------
  // Clear-on-read and register update
  // ---------------------------------------------------------------------------
  logic            clr_mm;
  logic            clr_mb;
  logic [NSPR-1:0] base_mm;
  logic [NSPR-1:0] base_mb;

  assign clr_mm  = reg_rd && (reg_addr == ADDR_MM);
  assign clr_mb  = reg_rd && (reg_addr == ADDR_MD);
  assign base_mm = clr_mm ? '0 : mm_q;
  assign base_mb = clr_mb ? '0 : md_q;

  always_comb begin
    // Collision latches: new bits are OR-ed on top of the (possibly cleared)
    // base, so a hit landing in the read clk survives the clear.
    mm_d = base_mm | new_mm;
    md_d = base_mb | new_mb;

    // IRQ only on the empty -> non-empty transition of the register.
    irq_mmc_d = (base_mm == '0) && (new_mm != '0);
    irq_mbc_d = (base_mb == '0) && (new_mb != '0);

    // Pixel path holds between pixel slots.
    pixel_out_d = pixel_out_q;
    spr_hit_d   = spr_hit_q;
    if (pix_en) begin
      if (!win_any || win_behind) begin
        pixel_out_d = bg_pix;
        spr_hit_d   = 1'b0;
      end else begin
        pixel_out_d = win_pix;
        spr_hit_d   = 1'b1;
      end
    end

    // Read port returns the pre-clear register value.
    rd_hit_d  = 1'b0;
    rd_data_d = rd_data_q;
    if (reg_rd) begin
      if (clr_mm) begin
        rd_hit_d  = 1'b1;
        rd_data_d = 8'(mm_q);
      end else if (clr_mb) begin
        rd_hit_d  = 1'b1;
        rd_data_d = 8'(md_q);
      end else begin
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out_q <= '0;
      spr_hit_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_hit_q    <= 1'b0;
      irq_mmc_q   <= 1'b0;
      irq_mbc_q   <= 1'b0;
      mm_q        <= '0;
      md_q        <= '0;
    end else begin
      pixel_out_q <= pixel_out_d;
      spr_hit_q   <= spr_hit_d;
      rd_data_q   <= rd_data_d;
      rd_hit_q    <= rd_hit_d;
      irq_mmc_q   <= irq_mmc_d;
      irq_mbc_q   <= irq_mbc_d;
      mm_q        <= mm_d;
      md_q        <= md_d;
    end
  end

  assign pixel_out = pixel_out_q;
  assign spr_hit   = spr_hit_q;
  assign rd_data   = rd_data_q;
  assign rd_hit    = rd_hit_q;
  assign irq_mmc   = irq_mmc_q;
  assign irq_mbc   = irq_mbc_q;

endmodule

// File: tb/tb_vicii_sprite_mux.sv
// tb/tb_vicii_sprite_mux.sv - scoreboard bench for vicii_sprite_mux
module tb_vicii_sprite_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [7:0]  spr_en;
  logic [31:0] spr_pix;
  logic [7:0]  me;
  logic [7:0]  mdp;
  logic [3:0]  bg_pix;
  logic        bg_fg;
  logic        reg_rd;
  logic [5:0]  reg_addr;
  logic [3:0]  pixel_out;
  logic        spr_hit;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic        irq_mmc;
  logic        irq_mbc;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] pix;
    logic       hit;
    logic [7:0] rdd;
    logic       rdh;
    logic       imm;
    logic       imb;
  } exp_t;

  exp_t sb[$];

  // Reference state
  logic [7:0] m_mm, m_md, m_rdd;
  logic [3:0] m_pix;
  logic       m_hit, m_rdh;

  always #5 clk = ~clk;

  vicii_sprite_mux #(.NSPR(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .spr_en    (spr_en),
    .spr_pix   (spr_pix),
    .ME        (me),
    .MDP       (mdp),
    .bg_pix    (bg_pix),
    .bg_fg     (bg_fg),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .pixel_out (pixel_out),
    .spr_hit   (spr_hit),
    .rd_data   (rd_data),
    .rd_hit    (rd_hit),
    .irq_mmc   (irq_mmc),
    .irq_mbc   (irq_mbc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Computes what the DUT must show after the coming edge and queues it.
  task automatic predict();
    exp_t       e;
    logic [7:0] act, nm, nb, bm, bb;
    int         cnt, w;
    bit         found;
    logic       imm, imb;
    if (reset) begin
      m_mm = 0; m_md = 0; m_rdd = 0; m_pix = 0; m_hit = 0; m_rdh = 0;
      imm = 0; imb = 0;
    end else begin
      act = spr_en & me;
      cnt = 0; found = 0; w = 0;
      for (int i = 0; i < 8; i++) begin
        if (act[i]) begin
          cnt++;
          if (!found) begin found = 1; w = i; end
        end
      end
      nm = (pix_en && cnt >= 2) ? act : 8'h00;
      nb = (pix_en && bg_fg) ? act : 8'h00;
      m_rdh = 0;
      if (reg_rd) begin
        if (reg_addr == 6'h1E)      begin m_rdd = m_mm; m_rdh = 1; end
        else if (reg_addr == 6'h1F) begin m_rdd = m_md; m_rdh = 1; end
        else                              m_rdd = 8'h00;
      end
      bm = (reg_rd && reg_addr == 6'h1E) ? 8'h00 : m_mm;
      bb = (reg_rd && reg_addr == 6'h1F) ? 8'h00 : m_md;
      imm = (bm == 0) && (nm != 0);
      imb = (bb == 0) && (nb != 0);
      m_mm = bm | nm;
      m_md = bb | nb;
      if (pix_en) begin
        if (!found || (mdp[w] && bg_fg)) begin m_pix = bg_pix; m_hit = 0; end
        else begin m_pix = spr_pix[4*w +: 4]; m_hit = 1; end
      end
    end
    e.pix = m_pix; e.hit = m_hit; e.rdd = m_rdd; e.rdh = m_rdh;
    e.imm = imm; e.imb = imb;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("pixel_out", pixel_out, e.pix);
      check("spr_hit",   spr_hit,   e.hit);
      check("rd_data",   rd_data,   e.rdd);
      check("rd_hit",    rd_hit,    e.rdh);
      check("irq_mmc",   irq_mmc,   e.imm);
      check("irq_mbc",   irq_mbc,   e.imb);
    end
  endtask

  task automatic rd(input logic [5:0] a);
    reg_rd = 1; reg_addr = a;
    cycle();
    reg_rd = 0;
  endtask

  task automatic set_pix(input int n, input logic [3:0] c);
    spr_pix[4*n +: 4] = c;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; pix_en = 0; spr_en = 0; spr_pix = 0; me = 0; mdp = 0;
    bg_pix = 0; bg_fg = 0; reg_rd = 0; reg_addr = 0;
    m_mm = 0; m_md = 0; m_rdd = 0; m_pix = 0; m_hit = 0; m_rdh = 0;
    @(negedge clk);
    cycle(); cycle();
    check("reset_pix", pixel_out, 4'h0);
    check("reset_rd",  rd_data,   8'h00);
    reset = 0;

    // Priority: sprites 1 and 2 active, sprite 1 wins
    pix_en = 1; me = 8'hFF; spr_en = 8'h06; bg_pix = 4'h9;
    set_pix(1, 4'h3); set_pix(2, 4'h7);
    cycle();
    check("prio_pix", pixel_out, 4'h3);
    check("prio_hit", spr_hit, 1'b1);
    check("prio_irq", irq_mmc, 1'b1);
    spr_en = 0;
    cycle();
    check("irq_pulse", irq_mmc, 1'b0);
    check("bg_pix", pixel_out, 4'h9);

    // Clear-on-read
    rd(6'h1E);
    check("rd_mm_06", rd_data, 8'h06);
    check("rd_hit", rd_hit, 1'b1);
    rd(6'h1E);
    check("rd_mm_00", rd_data, 8'h00);
    spr_en = 8'h06; cycle(); spr_en = 0; cycle();
    spr_en = 8'h18; rd(6'h1E); spr_en = 0;
    check("rd_clr_06", rd_data, 8'h06);
    check("rd_clr_irq", irq_mmc, 1'b1);
    rd(6'h1E);
    check("rd_mm_18", rd_data, 8'h18);

    // Behind graphics
    spr_en = 8'h01; mdp = 8'h01; bg_fg = 1; bg_pix = 4'h5; set_pix(0, 4'hC);
    cycle();
    check("behind_pix", pixel_out, 4'h5);
    check("behind_hit", spr_hit, 1'b0);
    check("behind_irq", irq_mbc, 1'b1);
    spr_en = 0; bg_fg = 0;
    cycle();
    check("mbc_pulse", irq_mbc, 1'b0);
    rd(6'h1F);
    check("rd_md_01", rd_data, 8'h01);

    // Winner behind graphics hides a front sprite below it
    spr_en = 8'h03; bg_fg = 1; bg_pix = 4'h2;
    cycle();
    check("hidden_pix", pixel_out, 4'h2);
    spr_en = 0; bg_fg = 0;
    rd(6'h1E); rd(6'h1F);

    // Gating by ME, then by pix_en
    me = 8'h00; spr_en = 8'h01; bg_pix = 4'hA; bg_fg = 1;
    cycle();
    check("gate_pix", pixel_out, 4'hA);
    check("gate_mbc", irq_mbc, 1'b0);
    me = 8'hFF; pix_en = 0; spr_en = 8'h03; bg_pix = 4'h4;
    cycle(); cycle();
    check("hold_pix", pixel_out, 4'hA);
    check("hold_irq", irq_mmc, 1'b0);
    pix_en = 1; spr_en = 0; bg_fg = 0;
    rd(6'h1E);
    check("hold_mm", rd_data, 8'h00);

    // No re-IRQ when adding bits
    spr_en = 8'h06; cycle();
    spr_en = 8'h21; cycle();
    check("no_reirq", irq_mmc, 1'b0);
    spr_en = 0;
    rd(6'h1E);
    check("rd_mm_27", rd_data, 8'h27);
    rd(6'h15);
    check("rd_other_hit", rd_hit, 1'b0);
    check("rd_other_data", rd_data, 8'h00);

    // Random traffic against the reference
    for (int n = 0; n < 300; n++) begin
      pix_en  = ($urandom_range(0, 3) != 0);
      spr_en  = 8'($urandom);
      spr_pix = $urandom;
      me      = 8'($urandom) | 8'h0F;
      mdp     = 8'($urandom);
      bg_pix  = 4'($urandom);
      bg_fg   = 1'($urandom);
      reg_rd  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       reg_addr = 6'h1E;
        1:       reg_addr = 6'h1F;
        default: reg_addr = 6'($urandom);
      endcase
      cycle();
    end
    reg_rd = 0;

    // Reset mid-operation
    pix_en = 1; me = 8'hFF; spr_en = 8'hFF; bg_fg = 1;
    cycle();
    reset = 1;
    cycle();
    check("rst_irq", irq_mmc, 1'b0);
    check("rst_hit", spr_hit, 1'b0);
    reset = 0; spr_en = 0; bg_fg = 0;
    rd(6'h1E);
    check("rst_mm", rd_data, 8'h00);
    rd(6'h1F);
    check("rst_md", rd_data, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
